ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Shares the single external RAM port between two block caches: requester 0 is the instruction cache and requester 1 is the data cache. It sits between the caches' RAM-side ports and the memory controller. Round-robin arbitration grants the port to one cache for one whole block burst of 2**BLOCKSIZEBITS words. A gap timeout reclaims the port if a burst is abandoned.

## Interface
- BLOCKSIZEBITS, 2, log2 of words per cache block; one grant covers 2**BLOCKSIZEBITS completed transfers.
- GAPTIMEOUT, 4, consecutive idle cycles of the grant holder before the grant is revoked; range 2..15.
- Clock  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- CacheNSchreiben / CacheNLesen  in  1 each  level requests from cache N (N = 0, 1).
- CacheNAdresse  in  32  word address from cache N.
- CacheNSchreibDaten  in  32  write data from cache N.
- CacheNLesDaten  out  32  read data to cache N.
- CacheNDatenGeschrieben / CacheNDatenGelesen  out  1 each  one-cycle completion strobes to cache N.
- RAMSchreiben / RAMLesen  out  1 each  forwarded request levels.
- RAMAdresse / RAMSchreibDaten  out  32 each  forwarded address and write data.
- RAMLesDaten  in  32  read data from RAM.
- RAMDatenGeschrieben / RAMDatenGelesen  in  1 each  completion strobes from RAM.
- Grant  out  2  one-hot current owner; 2'b00 when free.

## Operation
- Request: reqN = CacheNSchreiben | CacheNLesen. If both are high, the write wins and RAMLesen is forced to 0.
- States (one-hot):
  - IDLE: no owner.
  - BUSY: owner is requesting; requests are forwarded.
  - GAP: owner is between words.
- IDLE:
  - Only req0 high: grant 0. Only req1 high: grant 1.
  - Both high: grant the requester that is not `last`. `last` resets to 1, so requester 0 wins first.
  - Go to BUSY, clear the word counter and the gap counter.
- BUSY: RAM outputs mirror the owner's inputs combinationally.
  - A RAM strobe matching the forwarded direction is a completion. It pulses the owner's matching strobe in the same cycle and increments the word counter (BLOCKSIZEBITS wide).
  - Completion that wraps the counter to 0: release. Go to IDLE, set `last` to the owner, Grant becomes 0 on the next cycle.
  - Owner request low: go to GAP.
- GAP: RAM outputs are 0.
  - Owner request high: go to BUSY. The request is forwarded from the next cycle.
  - Otherwise increment the gap counter. When it reaches GAPTIMEOUT, release as above; the partial counter is discarded.
- While the port is owned, the non-owner's requests are ignored and its strobes stay 0.
- RAM strobes arriving outside BUSY are ignored.
- RAMLesDaten is fanned out unchanged to both CacheNLesDaten. It is valid only alongside the matching strobe.
- RAM outputs are 0 whenever state is not BUSY.
- A write-back burst followed by a refill burst counts as two separate grants. The other cache may be served in between.

## Timing
- Reset (async, low): state IDLE, `last`=1, both counters 0. Grant=0 and all RAM and cache outputs are 0 immediately, with no clock edge needed.
- Arbitration latency is 1 cycle: a request is seen in IDLE in cycle t, and RAM signals are asserted in cycle t+1.
- Completion strobes to the cache are combinational from the RAM strobes, with zero added latency.
- Owner re-request latency after a gap is 1 cycle. A cache inserting a 1-cycle gap between words therefore sees a 2-cycle gap on RAM.
- Back-to-back grants need a minimum of 1 IDLE cycle between the releasing completion and the next grant.
- Deassertion of Reset is synchronised internally; the first grant can occur on the second rising edge after release.
- A completion and the timeout never coincide, because completions only occur in BUSY.

## Structure
- Shared package ram_arbiter_pkg holds:
  - the one-hot state localparams ARB_IDLE=3'b001, ARB_BUSY=3'b010, ARB_GAP=3'b100;
  - the requester IDs REQ_I=0 and REQ_D=1.
- Sub-module rr_pick2: combinational round-robin chooser with inputs (req[1:0], last) and output grant[1:0] one-hot.
- Top level holds the FSM, the counters and the request/response muxes.

## Test plan
- Single read burst: Cache0Lesen held at Adresse 0x100, RAM answers each word in 3 cycles, cache gaps 1 cycle between words -> RAMAdresse follows 0x100..0x103, 4 Cache0DatenGelesen pulses, Grant 2'b01 then 2'b00.
- Simultaneous request: both caches raise read in the same cycle after reset -> cache 0 completes a full burst, then cache 1. Next simultaneous request -> cache 1 wins.
- Starvation guard: cache 1 requests during cache 0's burst -> Cache1DatenGelesen stays 0 and RAMAdresse never shows cache 1's address until cache 0's 4th completion, then Grant=2'b10 one cycle after the IDLE cycle.
- Write-then-read (dirty miss): cache 1 writes 4 words to 0x200..0x203, then reads 0x400..0x403 while cache 0 is requesting -> cache 0's burst is served between the write-back and the refill; data matches.
- Abandoned burst: cache 0 drops its request after 2 completions -> Grant is released after GAPTIMEOUT=4 idle cycles and cache 1 is then granted.
- Reset mid-burst: Reset pulled low while BUSY with RAMSchreiben=1 -> RAMSchreiben, Grant and strobes are 0 in the same cycle. After release, a new cache 0 request restarts at word count 0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-cache RAM port arbiter: one-hot state
// encodings and requester IDs.
package ram_arbiter_pkg;

  localparam logic [2:0] ARB_IDLE = 3'b001;
  localparam logic [2:0] ARB_BUSY = 3'b010;
  localparam logic [2:0] ARB_GAP  = 3'b100;

  localparam int REQ_I = 0;
  localparam int REQ_D = 1;

  typedef enum logic [2:0] {
    S_IDLE = ARB_IDLE,
    S_BUSY = ARB_BUSY,
    S_GAP  = ARB_GAP
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin chooser: a lone requester wins, on a tie the
// requester that did not hold the port last wins.
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == 1'(REQ_D)) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between the instruction cache (0) and data cache (1),
// one block burst per grant, with a gap timeout for abandoned bursts.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int BLOCKSIZEBITS = 2,
  parameter int GAPTIMEOUT    = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Cache0Schreiben,
  input  logic        Cache0Lesen,
  input  logic [31:0] Cache0Adresse,
  input  logic [31:0] Cache0SchreibDaten,
  output logic [31:0] Cache0LesDaten,
  output logic        Cache0DatenGeschrieben,
  output logic        Cache0DatenGelesen,
  input  logic        Cache1Schreiben,
  input  logic        Cache1Lesen,
  input  logic [31:0] Cache1Adresse,
  input  logic [31:0] Cache1SchreibDaten,
  output logic [31:0] Cache1LesDaten,
  output logic        Cache1DatenGeschrieben,
  output logic        Cache1DatenGelesen,
  output logic        RAMSchreiben,
  output logic        RAMLesen,
  output logic [31:0] RAMAdresse,
  output logic [31:0] RAMSchreibDaten,
  input  logic [31:0] RAMLesDaten,
  input  logic        RAMDatenGeschrieben,
  input  logic        RAMDatenGelesen,
  output logic [1:0]  Grant,
  output arb_state_t  arb_state
);

  localparam logic [3:0]               GAP_LIMIT = 4'(GAPTIMEOUT);
  localparam logic [BLOCKSIZEBITS-1:0] WORD_ONE  = BLOCKSIZEBITS'(1);

  // Handshake: a cache holds its request level (with stable address/data)
  // until the matching completion strobe; a strobe is a one-cycle accept.

  logic                     rst_q;
  arb_state_t               state, state_n;
  logic                     owner, owner_n;
  logic                     last, last_n;
  logic [BLOCKSIZEBITS-1:0] word_cnt, word_n;
  logic [3:0]               gap_cnt, gap_n, gap_inc;
  logic [1:0]               req, pick;
  logic                     own_wr, own_rd, own_req, busy;
  logic [31:0]              own_addr, own_wdata;
  logic                     done_wr, done_rd, done;

  // Assertion is immediate, release takes effect on the next rising edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) rst_q <= 1'b0;
    else        rst_q <= 1'b1;
  end

  assign req = {Cache1Schreiben | Cache1Lesen, Cache0Schreiben | Cache0Lesen};

  rr_pick2 u_pick (
    .req   (req),
    .last  (last),
    .grant (pick)
  );

  assign own_wr    = owner ? Cache1Schreiben    : Cache0Schreiben;
  assign own_rd    = owner ? Cache1Lesen        : Cache0Lesen;
  assign own_addr  = owner ? Cache1Adresse      : Cache0Adresse;
  assign own_wdata = owner ? Cache1SchreibDaten : Cache0SchreibDaten;
  assign own_req   = own_wr | own_rd;
  assign busy      = (state == S_BUSY);

  assign RAMSchreiben    = busy & own_wr;
  assign RAMLesen        = busy & own_rd & ~own_wr;
  assign RAMAdresse      = busy ? own_addr  : 32'h0;
  assign RAMSchreibDaten = busy ? own_wdata : 32'h0;

  assign done_wr = RAMSchreiben & RAMDatenGeschrieben;
  assign done_rd = RAMLesen & RAMDatenGelesen;
  assign done    = done_wr | done_rd;

  assign Cache0DatenGeschrieben = done_wr & ~owner;
  assign Cache1DatenGeschrieben = done_wr &  owner;
  assign Cache0DatenGelesen     = done_rd & ~owner;
  assign Cache1DatenGelesen     = done_rd &  owner;
  assign Cache0LesDaten         = rst_q ? RAMLesDaten : 32'h0;
  assign Cache1LesDaten         = rst_q ? RAMLesDaten : 32'h0;

  assign Grant     = (state == S_IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
  assign arb_state = state;
  assign gap_inc   = gap_cnt + 4'd1;

  always_ff @(posedge Clock or negedge rst_q) begin
    if (!rst_q) begin
      state    <= S_IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      word_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      last     <= last_n;
      word_cnt <= word_n;
      gap_cnt  <= gap_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    word_n  = word_cnt;
    gap_n   = gap_cnt;
    case (state)
      S_IDLE: begin
        if (pick != 2'b00) begin
          state_n = S_BUSY;
          owner_n = pick[1];
          word_n  = '0;
          gap_n   = '0;
        end
      end
      S_BUSY: begin
        if (done) begin
          word_n = word_cnt + WORD_ONE;
          if (&word_cnt) begin
            state_n = S_IDLE;
            last_n  = owner;
          end
        end else if (!own_req) begin
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (own_req) begin
          state_n = S_BUSY;
          gap_n   = '0;
        end else if (gap_inc == GAP_LIMIT) begin
          // Abandoned burst: the partial word count dies with the grant.
          state_n = S_IDLE;
          last_n  = owner;
          gap_n   = '0;
        end else begin
          gap_n = gap_inc;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: cache driver tasks, a 3-cycle RAM model,
// a read-data scoreboard and a grant-order log.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_wr [2];
  logic        c_rd [2];
  logic [31:0] c_addr [2];
  logic [31:0] c_wdata [2];
  logic [31:0] ld0, ld1;
  logic        dg0, dl0, dg1, dl1;
  logic        ram_wr, ram_rd;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic        ram_dg = 1'b0;
  logic        ram_dl = 1'b0;
  logic [1:0]  grant;
  arb_state_t  arb_state;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] shadow [logic [31:0]];
  logic [31:0] mem [logic [31:0]];
  logic [1:0]  grant_log[$];
  logic [1:0]  grant_prev = 2'b00;
  int          ram_cnt = 0;
  bit          inject = 1'b0;

  ram_arbiter #(.BLOCKSIZEBITS(2), .GAPTIMEOUT(4)) dut (
    .Clock                  (clk),
    .Reset                  (rst_n),
    .Cache0Schreiben        (c_wr[0]),
    .Cache0Lesen            (c_rd[0]),
    .Cache0Adresse          (c_addr[0]),
    .Cache0SchreibDaten     (c_wdata[0]),
    .Cache0LesDaten         (ld0),
    .Cache0DatenGeschrieben (dg0),
    .Cache0DatenGelesen     (dl0),
    .Cache1Schreiben        (c_wr[1]),
    .Cache1Lesen            (c_rd[1]),
    .Cache1Adresse          (c_addr[1]),
    .Cache1SchreibDaten     (c_wdata[1]),
    .Cache1LesDaten         (ld1),
    .Cache1DatenGeschrieben (dg1),
    .Cache1DatenGelesen     (dl1),
    .RAMSchreiben           (ram_wr),
    .RAMLesen               (ram_rd),
    .RAMAdresse             (ram_addr),
    .RAMSchreibDaten        (ram_wdata),
    .RAMLesDaten            (ram_rdata),
    .RAMDatenGeschrieben    (ram_dg),
    .RAMDatenGelesen        (ram_dl),
    .Grant                  (grant),
    .arb_state              (arb_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- RAM model: strobe on the 3rd cycle of a request ----------------
  always @(posedge clk) begin
    #2;
    ram_dg = 1'b0;
    ram_dl = 1'b0;
    if (ram_wr || ram_rd) begin
      ram_cnt++;
      if (ram_cnt == 3) begin
        ram_cnt = 0;
        if (ram_wr) begin
          ram_dg = 1'b1;
          mem[ram_addr] = ram_wdata;
        end else begin
          ram_dl = 1'b1;
          ram_rdata = mem.exists(ram_addr) ? mem[ram_addr] : ~ram_addr;
        end
      end
    end else begin
      ram_cnt = 0;
    end
    if (inject) ram_dl = 1'b1;
  end

  // ---------------- grant order log ----------------
  always @(posedge clk) begin
    #1;
    if (grant != grant_prev && grant != 2'b00) grant_log.push_back(grant);
    grant_prev = grant;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : ~a;
  endfunction

  function automatic logic strb(input int n, input bit wr);
    if (n == 0) return wr ? dg0 : dl0;
    return wr ? dg1 : dl1;
  endfunction

  function automatic logic any_strb(input int n);
    return (n == 0) ? (dg0 | dl0) : (dg1 | dl1);
  endfunction

  task automatic drive(input int n, input bit wr, input logic [31:0] a);
    c_addr[n]  = a;
    c_wr[n]    = wr;
    c_rd[n]    = !wr;
    c_wdata[n] = 32'hD000_0000 | a;
    if (wr) shadow[a] = 32'hD000_0000 | a;
    else if (n == 0) exp_q0.push_back(exp_rd(a));
    else exp_q1.push_back(exp_rd(a));
  endtask

  task automatic release_req(input int n);
    c_wr[n] = 1'b0;
    c_rd[n] = 1'b0;
  endtask

  task automatic burst(input int n, input bit wr, input logic [31:0] base,
                       input int words, input int gap, input bit full);
    logic [1:0]  own;
    logic [31:0] e;
    bit          seen;
    own = (n == 0) ? 2'b01 : 2'b10;
    for (int w = 0; w < words; w++) begin
      if (w == 0 || gap > 0) begin
        @(posedge clk); #1;
        drive(n, wr, base + w);
      end
      seen = 1'b0;
      for (int t = 0; t < 200 && !seen; t++) begin
        @(negedge clk);
        if (grant != own) begin
          check("foreign_strobe", 32'(any_strb(n)), 32'h0);
          check("foreign_addr", 32'((ram_wr | ram_rd) && ram_addr == c_addr[n]), 32'h0);
        end else if (strb(n, wr)) begin
          seen = 1'b1;
          check("ram_addr", ram_addr, base + w);
          if (!wr) begin
            e = 32'h0;
            if (n == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
            if (n == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
            check("rd_data", (n == 0) ? ld0 : ld1, e);
          end
        end
      end
      check("strobe_seen", 32'(seen), 32'h1);
      @(posedge clk); #1;
      if (w == words - 1 || gap > 0) release_req(n);
      else drive(n, wr, base + w + 1);
      @(negedge clk);
      check("grant_after", 32'(grant), (w == words - 1 && full) ? 32'h0 : 32'(own));
      if (gap > 1 && w < words - 1) repeat (gap - 1) @(posedge clk);
    end
  endtask

  task automatic check_log(input logic [1:0] e0, input logic [1:0] e1,
                           input logic [1:0] e2, input int n);
    logic [1:0] e [3];
    e = '{e0, e1, e2};
    check("log_len", 32'(grant_log.size()), 32'(n));
    for (int i = 0; i < n && i < grant_log.size(); i++)
      check("log_order", 32'(grant_log[i]), 32'(e[i]));
    grant_log.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit seen;
    for (int i = 0; i < 2; i++) begin
      c_wr[i] = 1'b0; c_rd[i] = 1'b0; c_addr[i] = 32'h0; c_wdata[i] = 32'h0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_state", 32'(arb_state), 32'(ARB_IDLE));
    check("rst_ram", {30'h0, ram_wr, ram_rd}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    grant_log.delete();

    // Simultaneous request after reset: cache 0 first (with 1-cycle gaps), cache 1 held off
    fork
      begin
        burst(0, 1'b0, 32'h100, 4, 1, 1'b1);
        @(negedge clk);
        check("handover", 32'(grant), 32'h2);
      end
      burst(1, 1'b0, 32'h180, 4, 0, 1'b1);
    join
    check_log(2'b01, 2'b10, 2'b00, 2);

    // After cache 0 held the port last, a tie goes to cache 1
    burst(0, 1'b0, 32'h140, 4, 0, 1'b1);
    fork
      burst(0, 1'b0, 32'h160, 4, 0, 1'b1);
      burst(1, 1'b0, 32'h1C0, 4, 0, 1'b1);
    join
    check_log(2'b01, 2'b10, 2'b01, 3);

    // Dirty miss: write-back and refill are separate grants, cache 0 served between
    fork
      begin
        burst(1, 1'b1, 32'h200, 4, 0, 1'b1);
        burst(1, 1'b0, 32'h400, 4, 1, 1'b1);
      end
      begin
        repeat (2) @(posedge clk);
        burst(0, 1'b0, 32'h600, 4, 0, 1'b1);
      end
    join
    check_log(2'b10, 2'b01, 2'b10, 3);
    burst(0, 1'b0, 32'h200, 4, 0, 1'b1);
    grant_log.delete();

    // Stray RAM strobe while idle is ignored
    @(posedge clk); #1;
    inject = 1'b1;
    @(negedge clk);
    check("stray_strobe", {30'h0, dl0, dl1}, 32'h0);
    check("stray_grant", 32'(grant), 32'h0);
    @(posedge clk); #1;
    inject = 1'b0;
    @(negedge clk);
    check("stray_state", 32'(arb_state), 32'(ARB_IDLE));

    // Abandoned burst: timeout after the gap, then cache 1 granted
    burst(0, 1'b0, 32'h300, 2, 0, 1'b0);
    c_addr[1] = 32'h500;
    c_rd[1]   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abandon_grant", 32'(grant), (i < 4) ? 32'h1 : ((i == 4) ? 32'h0 : 32'h2));
      check("abandon_ram_rd", 32'(ram_rd), (i == 5) ? 32'h1 : 32'h0);
    end
    burst(1, 1'b0, 32'h500, 4, 0, 1'b1);
    grant_log.delete();

    // Reset in the middle of a write burst
    @(posedge clk); #1;
    c_addr[0] = 32'h700; c_wdata[0] = 32'hD000_0700; c_wr[0] = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = dg0;
    end
    check("pre_rst_strobe", 32'(seen), 32'h1);
    @(negedge clk);
    check("pre_rst_wr", 32'(ram_wr), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_wr", 32'(ram_wr), 32'h0);
    check("rst_mid_grant", 32'(grant), 32'h0);
    check("rst_mid_strobes", {28'h0, dg0, dl0, dg1, dl1}, 32'h0);
    c_wr[0] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    burst(0, 1'b0, 32'h800, 4, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
